// File: rtl/gsim_param.sv
// Iterative Gauss-Seidel solver for the banded symmetric Toeplitz system (-1, 6, -13, 20, -13, 6, -1).
// Optional early convergence exit is enabled by defining GSIM_EARLY_EXIT_EN.
module gsim_param #(
  parameter int N       = 16,
  parameter int B_WIDTH = 16,
  parameter int X_WIDTH = 32,
  parameter int X_FRAC  = 16,
  parameter int ITER_W  = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_en,
  input  logic signed [B_WIDTH-1:0] b_in,
  input  logic        [ITER_W-1:0]  iter_max,
  input  logic        [X_WIDTH-1:0] tol_in,
  output logic                      busy,
  output logic                      out_valid,
  output logic signed [X_WIDTH-1:0] x_out,
  output logic        [ITER_W-1:0]  iter_cnt
);

  localparam int IDX_W = $clog2(N);
  localparam int S_W   = X_WIDTH + 6;
  localparam int P_W   = S_W + 33;
  localparam int Q_W   = P_W - 32;
  localparam int D_W   = X_WIDTH + 1;

  localparam logic signed [S_W-1:0] C13   = S_W'(13);
  localparam logic signed [S_W-1:0] C6    = S_W'(6);
  localparam logic signed [P_W-1:0] RECIP = P_W'(64'h0CCC_CCCD);
  localparam logic signed [P_W-1:0] ROUND = P_W'(64'h8000_0000);
  localparam logic signed [Q_W-1:0] Q_MAX = Q_W'((64'sd1 <<< (X_WIDTH - 1)) - 64'sd1);
  localparam logic signed [Q_W-1:0] Q_MIN = -Q_MAX - Q_W'(1);

  typedef enum logic [1:0] {IDLE, LOAD, SWEEP, OUT} state_t;

  state_t state, state_d;

  logic        [IDX_W-1:0]   idx;
  logic        [IDX_W-1:0]   idx_inc;
  logic        [ITER_W-1:0]  sweep;
  logic        [ITER_W-1:0]  sweep_inc;
  logic        [ITER_W-1:0]  iter_eff;
  logic signed [B_WIDTH-1:0] b_mem [N];
  logic signed [X_WIDTH-1:0] x_mem [N];

  logic signed [X_WIDTH-1:0] xm [1:3];
  logic signed [X_WIDTH-1:0] xp [1:3];
  logic signed [S_W-1:0]     s_sum;
  logic signed [P_W-1:0]     prod;
  logic signed [Q_W-1:0]     q;
  logic signed [X_WIDTH-1:0] x_new;

  logic load_last, row_last, out_last, finish, converged;

  assign idx_inc   = idx + IDX_W'(1);
  assign sweep_inc = sweep + ITER_W'(1);
  assign load_last = (idx == IDX_W'(N - 1));
  assign row_last  = load_last;
  assign out_last  = load_last;
  assign finish    = (sweep_inc == iter_eff) || converged;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    for (int k = 1; k <= 3; k++) begin
      xm[k] = '0;
      xp[k] = '0;
      if (int'(idx) - k >= 0) xm[k] = x_mem[IDX_W'(int'(idx) - k)];
      if (int'(idx) + k < N)  xp[k] = x_mem[IDX_W'(int'(idx) + k)];
    end
  end

  // Row update: S / 20 via a rounded fixed-point reciprocal, then clamp to the x range.
  always_comb begin
    s_sum = (S_W'(b_mem[idx]) <<< X_FRAC)
          + C13 * (S_W'(xm[1]) + S_W'(xp[1]))
          - C6  * (S_W'(xm[2]) + S_W'(xp[2]))
          + S_W'(xm[3]) + S_W'(xp[3]);
    prod  = P_W'(s_sum) * RECIP + ROUND;
    q     = Q_W'(prod >>> 32);
    if (q > Q_MAX)      x_new = {1'b0, {(X_WIDTH - 1){1'b1}}};
    else if (q < Q_MIN) x_new = {1'b1, {(X_WIDTH - 1){1'b0}}};
    else                x_new = X_WIDTH'(q);
  end

`ifdef GSIM_EARLY_EXIT_EN
  logic        [X_WIDTH-1:0] tol_q;
  logic        [D_W-1:0]     max_d;
  logic        [D_W-1:0]     cur_d;
  logic        [D_W-1:0]     sweep_max;
  logic signed [D_W-1:0]     diff;

  always_comb begin
    diff      = D_W'(x_new) - D_W'(x_mem[idx]);
    cur_d     = diff[X_WIDTH] ? D_W'(-diff) : D_W'(diff);
    sweep_max = (cur_d > max_d) ? cur_d : max_d;
    converged = (sweep_max <= {1'b0, tol_q});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tol_q <= '0;
      max_d <= '0;
    end else begin
      if (state == IDLE && in_en) tol_q <= tol_in;
      if (state == SWEEP) max_d <= row_last ? '0 : sweep_max;
      else                max_d <= '0;
    end
  end
`else
  logic tol_unused;
  assign tol_unused = ^tol_in;
  assign converged  = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:  if (in_en) state_d = LOAD;
      LOAD:  if (!in_en) state_d = IDLE;
             else if (load_last) state_d = SWEEP;
      SWEEP: if (row_last && finish) state_d = OUT;
      OUT:   if (out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the b buffer is fully rewritten before every use, so it carries no reset.
  always_ff @(posedge clk) begin
    if ((state == IDLE || state == LOAD) && in_en) b_mem[idx] <= b_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      sweep     <= '0;
      iter_eff  <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      x_out     <= '0;
      iter_cnt  <= '0;
      for (int i = 0; i < N; i++) x_mem[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_en) begin
            idx      <= IDX_W'(1);
            iter_eff <= (iter_max == '0) ? ITER_W'(1) : iter_max;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (!in_en) begin
            idx  <= '0;
            busy <= 1'b0;
          end else if (load_last) begin
            idx   <= '0;
            sweep <= '0;
            for (int i = 0; i < N; i++) x_mem[i] <= '0;
          end else begin
            idx <= idx_inc;
          end
        end
        SWEEP: begin
          x_mem[idx] <= x_new;
          if (row_last) begin
            idx   <= '0;
            sweep <= sweep_inc;
            // The first output word leaves on the final update edge; row 0 is already final.
            if (finish) begin
              out_valid <= 1'b1;
              x_out     <= x_mem[0];
              iter_cnt  <= sweep_inc;
            end
          end else begin
            idx <= idx_inc;
          end
        end
        OUT: begin
          if (out_last) begin
            idx       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            x_out     <= '0;
          end else begin
            idx   <= idx_inc;
            x_out <= x_mem[idx_inc];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gsim_param.sv
// Randomized self-checking bench for gsim_param against a sweep-level Gauss-Seidel model.
module tb_gsim_param;

  localparam int N = 16;
`ifdef GSIM_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               in_en;
  logic signed [15:0] b_in;
  logic        [9:0]  iter_max;
  logic        [31:0] tol_in;
  logic               busy;
  logic               out_valid;
  logic signed [31:0] x_out;
  logic        [9:0]  iter_cnt;

  gsim_param dut (
    .clk      (clk),
    .reset    (reset),
    .in_en    (in_en),
    .b_in     (b_in),
    .iter_max (iter_max),
    .tol_in   (tol_in),
    .busy     (busy),
    .out_valid(out_valid),
    .x_out    (x_out),
    .iter_cnt (iter_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic signed [15:0] tb_b [N];
  longint             mx [N];
  int                 m_iters;
  longint             got_x [N];

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint nb(input int i);
    if (i < 0 || i >= N) return 0;
    return mx[i];
  endfunction

  // Divide by 20 with the reciprocal 0x0CCCCCCD and round, then clamp to 32-bit signed.
  function automatic longint gs_div(input longint s);
    logic signed [95:0] p;
    p = 96'(s) * 96'sd214748365 + 96'sd2147483648;
    p = p >>> 32;
    if (p > 96'sd2147483647)  return 64'sd2147483647;
    if (p < -96'sd2147483648) return -64'sd2147483648;
    return longint'(p);
  endfunction

  task automatic run_model(input int it, input longint tol);
    int eff;
    eff = (it == 0) ? 1 : it;
    for (int i = 0; i < N; i++) mx[i] = 0;
    m_iters = 0;
    for (int s = 1; s <= eff; s++) begin
      longint maxd, sum, xn, d;
      maxd = 0;
      for (int i = 0; i < N; i++) begin
        sum = longint'(tb_b[i]) * 65536
            + 13 * (nb(i - 1) + nb(i + 1))
            - 6 * (nb(i - 2) + nb(i + 2))
            + nb(i - 3) + nb(i + 3);
        xn = gs_div(sum);
        d  = xn - mx[i];
        if (d < 0) d = -d;
        if (d > maxd) maxd = d;
        mx[i] = xn;
      end
      m_iters = s;
      if (EARLY && maxd <= tol) break;
    end
  endtask

  task automatic load_samples(input int it, input longint tol, input int nload);
    for (int k = 0; k < nload; k++) begin
      in_en    = 1'b1;
      b_in     = tb_b[k];
      iter_max = (k == 0) ? 10'(it) : 10'($urandom);
      tol_in   = (k == 0) ? 32'(tol) : $urandom;
      step();
    end
    in_en = 1'b0;
    b_in  = '0;
  endtask

  task automatic disturb_inputs(input bit en);
    if (en) begin
      in_en    = 1'($urandom_range(0, 1));
      b_in     = 16'($urandom);
      iter_max = 10'($urandom);
      tol_in   = $urandom;
    end
  endtask

  // Waits for the result stream after the last load edge and checks it against the model.
  task automatic collect(input string tag, input bit disturb);
    int lat;
    lat = -1;
    for (int c = 1; c <= m_iters * N + 20; c++) begin
      disturb_inputs(disturb);
      step();
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    check({tag, " latency"}, lat, m_iters * N);
    if (lat < 0) begin
      in_en = 1'b0;
      return;
    end
    for (int k = 0; k < N; k++) begin
      got_x[k] = longint'(x_out);
      check($sformatf("%s x[%0d]", tag, k), longint'(x_out), mx[k]);
      if (k == 0 || k == N - 1) begin
        check({tag, " iter_cnt"}, longint'(iter_cnt), m_iters);
        check({tag, " busy in out"}, longint'(busy), 1);
      end
      disturb_inputs(disturb);
      step();
      if (k < N - 1) check({tag, " out_valid held"}, longint'(out_valid), 1);
    end
    in_en = 1'b0;
    check({tag, " out_valid end"}, longint'(out_valid), 0);
    check({tag, " busy end"}, longint'(busy), 0);
  endtask

  task automatic run_problem(input string tag, input int it, input longint tol, input bit disturb);
    run_model(it, tol);
    load_samples(it, tol, N);
    collect(tag, disturb);
  endtask

  task automatic fill_b(input int mode);
    for (int i = 0; i < N; i++) begin
      case (mode)
        0:       tb_b[i] = '0;
        1:       tb_b[i] = 16'($signed($urandom_range(0, 600)) - 300);
        default: tb_b[i] = 16'($urandom);
      endcase
    end
  endtask

  initial begin
    longint ref_x [N];
    bit     seen;

    reset    = 1'b1;
    in_en    = 1'b0;
    b_in     = '0;
    iter_max = '0;
    tol_in   = '0;
    #12;
    check("reset busy", longint'(busy), 0);
    check("reset out_valid", longint'(out_valid), 0);
    check("reset x_out", longint'(x_out), 0);
    check("reset iter_cnt", longint'(iter_cnt), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();

    // Single unit excitation, one sweep.
    fill_b(0);
    tb_b[0] = 16'sd20;
    run_problem("unit", 1, 0, 1'b0);
    check("unit x0 const", got_x[0], 64'sh0001_0000);
    check("unit x1 const", got_x[1], 42598);
    check("unit x2 const", got_x[2], 8028);

    // Zero rhs: latency iter*N and all-zero solution.
    fill_b(0);
    run_problem("zero5", 5, 0, 1'b0);
    run_problem("zero100", 100, 0, 1'b0);
    fill_b(1);
    run_problem("iter0", 0, 0, 1'b0);

    // Aborted load followed by a full load.
    fill_b(1);
    load_samples(4, 0, 7);
    step();
    check("abort busy", longint'(busy), 0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) seen = 1'b1;
      step();
    end
    check("abort no output", longint'(seen), 0);
    run_problem("after abort", 4, 0, 1'b0);

    // Reset in the middle of a sweep.
    fill_b(1);
    load_samples(4, 0, N);
    for (int c = 0; c < 10; c++) step();
    #2;
    reset = 1'b1;
    #1;
    check("midreset busy", longint'(busy), 0);
    check("midreset out_valid", longint'(out_valid), 0);
    check("midreset x_out", longint'(x_out), 0);
    step();
    reset = 1'b0;
    step();
    fill_b(1);
    run_problem("after reset", 3, 0, 1'b0);

    // Disturbed run must equal the undisturbed one.
    fill_b(1);
    run_problem("quiet", 3, 0, 1'b0);
    for (int i = 0; i < N; i++) ref_x[i] = got_x[i];
    run_problem("disturbed", 3, 0, 1'b1);
    for (int i = 0; i < N; i++) check($sformatf("disturb same x[%0d]", i), got_x[i], ref_x[i]);

    // Randomized problems, back to back.
    for (int t = 0; t < 8; t++) begin
      fill_b((t % 3 == 2) ? 2 : 1);
      run_problem($sformatf("rand%0d", t), $urandom_range(1, 6), $urandom_range(0, 4000),
                  1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
